// File: rtl/seq_game_pkg.sv
// Shared types and constants for the sequence display controller.
// Holds the presentation FSM state type and the nibble-selection helper.
package seq_game_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int NIBBLE_W   = 4;
  localparam int SEQ_W      = NUM_DIGITS * NIBBLE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } disp_state_e;

  // The interval timer must hold the largest terminal count without wrapping.
  function automatic int timer_width(int ticks, int gap);
    return $clog2(((ticks > gap) ? ticks : gap) + 1);
  endfunction

  // Digit index 0 is the most significant nibble of the sequence.
  function automatic logic [NIBBLE_W-1:0] nibble_at(logic [SEQ_W-1:0] s, logic [2:0] idx);
    logic [SEQ_W-1:0] sh;
    sh = s >> (NIBBLE_W * (NUM_DIGITS - 1 - int'(idx)));
    return sh[NIBBLE_W-1:0];
  endfunction

endpackage

// File: rtl/seq_display_ctrl_if.sv
// Bus between the sequence generator (master) and the display controller (slave).
// The replay request exists only when SEQ_DISP_REPLAY_EN is defined.
interface seq_display_ctrl_if;
  import seq_game_pkg::*;

  logic                new_seq;
  logic [SEQ_W-1:0]    seq;
  logic [NIBBLE_W-1:0] digit_out;
  logic                digit_valid;
  logic [2:0]          digit_idx;
  logic                busy;
  logic                done;

`ifdef SEQ_DISP_REPLAY_EN
  logic                replay;

  modport master (output new_seq, seq, replay,
                  input  digit_out, digit_valid, digit_idx, busy, done);
  modport slave  (input  new_seq, seq, replay,
                  output digit_out, digit_valid, digit_idx, busy, done);
`else
  modport master (output new_seq, seq,
                  input  digit_out, digit_valid, digit_idx, busy, done);
  modport slave  (input  new_seq, seq,
                  output digit_out, digit_valid, digit_idx, busy, done);
`endif

endinterface

// File: rtl/seq_disp_timer.sv
// Interval counter: restarts from zero whenever not counting, flags when the
// count has reached the terminal value supplied by the controller.
module seq_disp_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_d = en_i ? cnt_q + W'(1) : '0;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == last_i);

endmodule

// File: rtl/seq_display_ctrl.sv
// Presents a latched 20-bit sequence one nibble at a time, MS nibble first.
// Optional replay of the last sequence is enabled by defining SEQ_DISP_REPLAY_EN.
module seq_display_ctrl
  import seq_game_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 50000000,
  parameter int GAP_TICKS       = 12500000
) (
  input logic              clk,
  input logic              rst,
  seq_display_ctrl_if.slave bus
);

  localparam int             TW        = timer_width(TICKS_PER_DIGIT, GAP_TICKS);
  localparam logic [TW-1:0]  SHOW_LAST = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0]  GAP_LAST  = (GAP_TICKS > 0) ? TW'(GAP_TICKS - 1) : '0;
  localparam logic [2:0]     LAST_IDX  = 3'(NUM_DIGITS - 1);

  disp_state_e         state_q;
  logic [SEQ_W-1:0]    latched_q, latched_d;
  logic [NIBBLE_W-1:0] digit_q;
  logic [2:0]          idx_q;
  logic                valid_q, busy_q, done_q;
  logic                start, timer_en, timer_expire;
  logic [TW-1:0]       timer_last;

`ifdef SEQ_DISP_REPLAY_EN
  assign start = bus.new_seq | (bus.replay & (state_q == IDLE));
`else
  assign start = bus.new_seq;
`endif

  // A replay reuses the held sequence; only new_seq loads a fresh one.
  assign latched_d  = bus.new_seq ? bus.seq : latched_q;
  assign timer_last = (state_q == GAP) ? GAP_LAST : SHOW_LAST;
  assign timer_en   = ((state_q == SHOW) || (state_q == GAP)) && !timer_expire && !start;

  seq_disp_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (timer_en),
    .last_i   (timer_last),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      latched_q <= '0;
      digit_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (start) begin
      // Any start, including one mid-presentation, restarts cleanly from digit 0.
      state_q   <= SHOW;
      latched_q <= latched_d;
      idx_q     <= '0;
      digit_q   <= nibble_at(latched_d, 3'd0);
      valid_q   <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: done_q <= 1'b0;
        SHOW: begin
          if (timer_expire) begin
            valid_q <= 1'b0;
            digit_q <= '0;
            if (GAP_TICKS > 0) begin
              state_q <= GAP;
            end else if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHOW;
              idx_q   <= idx_q + 3'd1;
              valid_q <= 1'b1;
              digit_q <= nibble_at(latched_q, idx_q + 3'd1);
            end
          end
        end
        GAP: begin
          if (timer_expire) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHOW;
              idx_q   <= idx_q + 3'd1;
              valid_q <= 1'b1;
              digit_q <= nibble_at(latched_q, idx_q + 3'd1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          digit_q <= '0;
          idx_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.digit_out   = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_idx   = idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
